// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory behind a valid/ready request channel.
// A request is accepted only in IDLE. It waits LATENCY cycles and then answers
// with a single-cycle response pulse. Storage is a register array rather than
// block RAM because every word must clear on reset.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_busy;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic                   w_misaligned;
    logic                   w_out_of_range;
    logic                   w_err;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_exec;
    logic                   w_store_en;
    logic [DEPTH_WORDS-1:0] w_word_we;

    // The range check uses the whole word address so high address bits never alias.
    assign w_misaligned   = (r_addr[1:0] != 2'b00);
    assign w_out_of_range = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err          = w_misaligned || w_out_of_range;
    assign w_idx          = r_addr[IDX_W+1:2];
    assign w_exec         = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_store_en     = w_exec && r_write && !w_err;

    // Each word gets its own write enable, decoded from the latched address.
    for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word_we
        assign w_word_we[gi] = w_store_en && (w_idx == IDX_W'(gi));
    end

    // Memory array: cleared on reset, written once at the end of a store's wait.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                if (w_word_we[i]) begin
                    r_mem[i] <= r_wdata;
                end
            end
        end
    end

    // Request FSM with registered handshake, response and busy outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_write <= req_write_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= ST_WAIT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Load data is sampled here. Stores and errors answer with zero data.
                        r_rdata      <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
                        r_err        <= w_err;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = r_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. The main instance uses LATENCY=2.
// Two more instances (LATENCY=1 and LATENCY=15) share a second request bus
// and are used for the latency round-trip test.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        b_valid, b_write;
    logic [31:0] b_addr, b_wdata;
    logic        l1_ready, l1_rvalid, l1_err, l1_busy;
    logic [31:0] l1_rdata;
    logic        l15_ready, l15_rvalid, l15_err, l15_busy;
    logic [31:0] l15_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .busy_o(busy)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_ready_o(l1_ready), .req_write_i(b_write),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .resp_valid_o(l1_rvalid), .resp_rdata_o(l1_rdata), .resp_err_o(l1_err),
        .busy_o(l1_busy)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(15)) dut_l15 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_ready_o(l15_ready), .req_write_i(b_write),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .resp_valid_o(l15_rvalid), .resp_rdata_o(l15_rdata), .resp_err_o(l15_err),
        .busy_o(l15_busy)
    );

    // Issue one request on the main bus, starting at a negedge in IDLE.
    // lat is the number of cycles after the accepting edge at which the
    // response pulse is seen (-1 on timeout). pulse_after is resp_valid one
    // cycle later. The task returns at a negedge in IDLE.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic pulse_after);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~a;
        req_wdata = ~d;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid === 1'b1) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pulse_after = resp_valid;
        $display("[TB] req wr=%0b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b",
                 wr, a, d, lat, rd, er);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_tests++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %08h expected 00000000", resp_rdata); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (l1_ready !== 1'b1 || l15_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_lat: got %b/%b expected 1/1", l1_ready, l15_ready); end
        $display("[TB] reset applied and released");
        rst = 1'b0;
    endtask

    task automatic test_bounds();
        int lat; logic [31:0] rd; logic er, pa;
        do_req(1'b0, 32'h0000_01FC, 32'h0, lat, rd, er, pa);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL top_word_lat: got %0d expected 2", lat); end
        n_tests++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL top_word_load: got rdata=%08h err=%b expected 00000000/0", rd, er); end
        do_req(1'b0, 32'h0000_0200, 32'h0, lat, rd, er, pa);
        n_tests++; if (rd !== 32'd0 || er !== 1'b1) begin n_fail++; $display("FAIL past_end_load: got rdata=%08h err=%b expected 00000000/1", rd, er); end
        do_req(1'b0, 32'h0000_1010, 32'h0, lat, rd, er, pa);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL high_bits_load: got err=%b expected 1", er); end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er, pa;
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, er, pa);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL store_lat: got %0d expected 2", lat); end
        n_tests++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL store_resp: got rdata=%08h err=%b expected 00000000/0", rd, er); end
        n_tests++; if (pa !== 1'b0) begin n_fail++; $display("FAIL store_pulse_width: got resp_valid=%b one cycle later expected 0", pa); end
        do_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, er, pa);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL load_lat: got %0d expected 2", lat); end
        n_tests++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL load_after_store: got rdata=%08h err=%b expected deadbeef/0", rd, er); end
        n_tests++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_hold: got %08h expected deadbeef", resp_rdata); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er, pa;
        do_req(1'b1, 32'h0000_0013, 32'h1234_5678, lat, rd, er, pa);
        n_tests++; if (rd !== 32'd0 || er !== 1'b1) begin n_fail++; $display("FAIL misaligned_store: got rdata=%08h err=%b expected 00000000/1", rd, er); end
        do_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, er, pa);
        n_tests++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL misaligned_no_write: got rdata=%08h err=%b expected deadbeef/0", rd, er); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, pa;
        logic exp_ready, exp_valid;
        for (int j = 0; j < 4; j++) begin
            do_req(1'b1, 32'h100 + 32'(16 * j), 32'h1111_0000 + 32'(j), lat, rd, er, pa);
        end
        // Cycle -1: valid goes high while IDLE. It then stays high, and the address changes every cycle.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b expected 1", req_ready); end
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_ready = ((c % 4) == 3);
            exp_valid = ((c % 4) == 2);
            n_tests++; if (req_ready !== exp_ready || busy !== !exp_ready) begin n_fail++; $display("FAIL b2b_ready c=%0d: got ready=%b busy=%b expected ready=%b", c, req_ready, busy, exp_ready); end
            n_tests++; if (resp_valid !== exp_valid) begin n_fail++; $display("FAIL b2b_resp_valid c=%0d: got %b expected %b", c, resp_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++; if (resp_rdata !== 32'h1111_0000 + 32'(c / 4)) begin n_fail++; $display("FAIL b2b_rdata c=%0d: got %08h expected %08h", c, resp_rdata, 32'h1111_0000 + 32'(c / 4)); end
            end
            $display("[TB] b2b cycle %0d ready=%b resp_valid=%b rdata=%08h", c, req_ready, resp_valid, resp_rdata);
            req_addr = 32'h100 + 32'(4 * ((c + 1) % 16));
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rd; logic er, pa;
        logic saw_pulse;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_busy: got %b expected 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_idle: got busy=%b ready=%b resp_valid=%b expected 0/1/0", busy, req_ready, resp_valid); end
        saw_pulse = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) saw_pulse = 1'b1;
        end
        n_tests++; if (saw_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_resp: got a response pulse expected none"); end
        $display("[TB] reset during WAIT of store 0x20");
        do_req(1'b0, 32'h20, 32'h0, lat, rd, er, pa);
        n_tests++; if (lat != 2 || rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_write: got lat=%0d rdata=%08h err=%b expected 2/00000000/0", lat, rd, er); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, er, pa);
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_clears_mem: got %08h expected 00000000", rd); end
    endtask

    task automatic test_latency_variants();
        int lat1, lat15, n1, n15;
        logic [31:0] rd1, rd15;
        for (int pass = 0; pass < 2; pass++) begin
            b_valid = 1'b1; b_write = (pass == 0); b_addr = 32'h4; b_wdata = 32'hCAFE_F00D;
            @(posedge clk);
            @(negedge clk);
            b_valid = 1'b0; b_wdata = 32'h0;
            lat1 = -1; lat15 = -1; n1 = 0; n15 = 0; rd1 = 'x; rd15 = 'x;
            for (int k = 0; k < 20; k++) begin
                if (l1_rvalid === 1'b1) begin n1++; if (lat1 < 0) begin lat1 = k; rd1 = l1_rdata; end end
                if (l15_rvalid === 1'b1) begin n15++; if (lat15 < 0) begin lat15 = k; rd15 = l15_rdata; end end
                @(negedge clk);
            end
            $display("[TB] latency pass %0d: L1 lat=%0d rdata=%08h  L15 lat=%0d rdata=%08h", pass, lat1, rd1, lat15, rd15);
            n_tests++; if (lat1 != 1 || n1 != 1) begin n_fail++; $display("FAIL lat1_timing pass=%0d: got lat=%0d pulses=%0d expected 1/1", pass, lat1, n1); end
            n_tests++; if (lat15 != 15 || n15 != 1) begin n_fail++; $display("FAIL lat15_timing pass=%0d: got lat=%0d pulses=%0d expected 15/1", pass, lat15, n15); end
            if (pass == 1) begin
                n_tests++; if (rd1 !== 32'hCAFE_F00D || rd15 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat_load_data: got %08h/%08h expected cafef00d/cafef00d", rd1, rd15); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bounds();
        test_store_load();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
        test_latency_variants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
